// File: rtl/vx_vset_tracker.sv
// Per-warp vector configuration table (vl, vtype) with an in-flight vset counter per warp.
// Queries are registered and write-first: they see the state produced by the same edge's updates.
module vx_vset_tracker #(
    parameter int NUM_WARPS   = 4,
    parameter int VL_BITS     = 8,
    parameter int MAX_PENDING = 3,
    localparam int WID_W      = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
    localparam int CNT_W      = $clog2(MAX_PENDING + 1)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               alloc_valid,
    input  logic [WID_W-1:0]   alloc_wid,
    output logic               alloc_ready,
    input  logic               commit_valid,
    input  logic [WID_W-1:0]   commit_wid,
    input  logic [VL_BITS-1:0] commit_vl,
    input  logic [7:0]         commit_vtype,
    input  logic               flush_valid,
    input  logic [WID_W-1:0]   flush_wid,
    input  logic               rd_valid,
    input  logic [WID_W-1:0]   rd_wid,
    output logic               rd_rsp_valid,
    output logic [VL_BITS-1:0] rd_vl,
    output logic [7:0]         rd_vtype,
    output logic               rd_busy,
    output logic               err
);

    localparam logic [7:0] VILL_VTYPE = 8'h80;

    typedef logic [CNT_W-1:0]   cnt_t;
    typedef logic [VL_BITS-1:0] vl_t;

    cnt_t       cnt_q   [NUM_WARPS];
    cnt_t       cnt_d   [NUM_WARPS];
    vl_t        vl_q    [NUM_WARPS];
    vl_t        vl_d    [NUM_WARPS];
    logic [7:0] vtype_q [NUM_WARPS];
    logic [7:0] vtype_d [NUM_WARPS];
    logic       err_q;
    logic       err_d;

    logic                 alloc_fire;
    logic [NUM_WARPS-1:0] a_hit;
    logic [NUM_WARPS-1:0] c_hit;
    logic [NUM_WARPS-1:0] f_hit;

    vl_t        q_vl;
    logic [7:0] q_vtype;
    logic       q_busy;

    // Readiness looks only at the registered count; an out-of-range warp is never ready.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        alloc_ready = 1'b0;
        for (int w = 0; w < NUM_WARPS; w++) begin
            if (alloc_wid == WID_W'(w)) begin
                alloc_ready = (cnt_q[w] < CNT_W'(MAX_PENDING));
            end
        end
    end

    assign alloc_fire = alloc_valid && alloc_ready;

    always_comb begin
        for (int w = 0; w < NUM_WARPS; w++) begin
            a_hit[w] = alloc_fire   && (alloc_wid  == WID_W'(w));
            c_hit[w] = commit_valid && (commit_wid == WID_W'(w));
            f_hit[w] = flush_valid  && (flush_wid  == WID_W'(w));
        end
    end

    // Next state for every warp; each warp only sees the ports that target it.
    always_comb begin
        cnt_d   = cnt_q;
        vl_d    = vl_q;
        vtype_d = vtype_q;
        err_d   = err_q;
        for (int w = 0; w < NUM_WARPS; w++) begin
            if (f_hit[w]) begin
                cnt_d[w] = a_hit[w] ? CNT_W'(1) : '0;
            end else if (a_hit[w] && c_hit[w]) begin
                cnt_d[w] = cnt_q[w];
            end else if (a_hit[w]) begin
                cnt_d[w] = cnt_q[w] + CNT_W'(1);
            end else if (c_hit[w]) begin
                if (cnt_q[w] == '0) begin
                    err_d = 1'b1;
                end else begin
                    cnt_d[w] = cnt_q[w] - CNT_W'(1);
                end
            end

            if (c_hit[w]) begin
                if (commit_vtype[7]) begin
                    vl_d[w]    = '0;
                    vtype_d[w] = VILL_VTYPE;
                end else begin
                    vl_d[w]    = commit_vl;
                    vtype_d[w] = commit_vtype;
                end
            end
        end
    end

    // Query reads the post-update state; unknown warps answer with reset values.
    always_comb begin
        q_vl    = '0;
        q_vtype = VILL_VTYPE;
        q_busy  = 1'b0;
        for (int w = 0; w < NUM_WARPS; w++) begin
            if (rd_wid == WID_W'(w)) begin
                q_vl    = vl_d[w];
                q_vtype = vtype_d[w];
                q_busy  = (cnt_d[w] != '0);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: the table is a few flops per warp, so it is reset like any other state.
            for (int w = 0; w < NUM_WARPS; w++) begin
                cnt_q[w]   <= '0;
                vl_q[w]    <= '0;
                vtype_q[w] <= VILL_VTYPE;
            end
            err_q        <= 1'b0;
            rd_rsp_valid <= 1'b0;
            rd_vl        <= '0;
            rd_vtype     <= VILL_VTYPE;
            rd_busy      <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only.
            cnt_q        <= cnt_d;
            vl_q         <= vl_d;
            vtype_q      <= vtype_d;
            err_q        <= err_d;
            rd_rsp_valid <= rd_valid;
            if (rd_valid) begin
                rd_vl    <= q_vl;
                rd_vtype <= q_vtype;
                rd_busy  <= q_busy;
            end
        end
    end

    assign err = err_q;

endmodule

// File: tb/tb_vx_vset_tracker.sv
// Self-checking bench for vx_vset_tracker: directed scenarios then random traffic,
// compared every cycle against a per-warp reference model of counts, table and error flag.
module tb_vx_vset_tracker;

    localparam int NW = 4;

    logic       clk;
    logic       reset_n;
    logic       alloc_valid;
    logic [1:0] alloc_wid;
    logic       alloc_ready;
    logic       commit_valid;
    logic [1:0] commit_wid;
    logic [7:0] commit_vl;
    logic [7:0] commit_vtype;
    logic       flush_valid;
    logic [1:0] flush_wid;
    logic       rd_valid;
    logic [1:0] rd_wid;
    logic       rd_rsp_valid;
    logic [7:0] rd_vl;
    logic [7:0] rd_vtype;
    logic       rd_busy;
    logic       err;

    vx_vset_tracker #(.NUM_WARPS(4), .VL_BITS(8), .MAX_PENDING(3)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .alloc_valid  (alloc_valid),
        .alloc_wid    (alloc_wid),
        .alloc_ready  (alloc_ready),
        .commit_valid (commit_valid),
        .commit_wid   (commit_wid),
        .commit_vl    (commit_vl),
        .commit_vtype (commit_vtype),
        .flush_valid  (flush_valid),
        .flush_wid    (flush_wid),
        .rd_valid     (rd_valid),
        .rd_wid       (rd_wid),
        .rd_rsp_valid (rd_rsp_valid),
        .rd_vl        (rd_vl),
        .rd_vtype     (rd_vtype),
        .rd_busy      (rd_busy),
        .err          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: pending count, stored config per warp, sticky error, expected response.
    int         m_cnt [NW];
    logic [7:0] m_vl  [NW];
    logic [7:0] m_vt  [NW];
    bit         m_err;
    bit         e_rv;
    logic [7:0] e_vl;
    logic [7:0] e_vt;
    bit         e_busy;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int w = 0; w < NW; w++) begin
            m_cnt[w] = 0;
            m_vl[w]  = 8'h00;
            m_vt[w]  = 8'h80;
        end
        m_err  = 0;
        e_rv   = 0;
        e_vl   = 8'h00;
        e_vt   = 8'h80;
        e_busy = 0;
    endtask

    // One clock: check readiness, take the edge, advance the model, check the response.
    task automatic cycle();
        bit exp_ready;
        bit a, c, f;
        #1;
        exp_ready = (m_cnt[alloc_wid] < 3);
        check("alloc_ready", alloc_ready, exp_ready);
        @(posedge clk);
        for (int w = 0; w < NW; w++) begin
            a = alloc_valid  && exp_ready && (alloc_wid == w);
            c = commit_valid && (commit_wid == w);
            f = flush_valid  && (flush_wid == w);
            if (f)           m_cnt[w] = a ? 1 : 0;
            else if (a && c) m_cnt[w] = m_cnt[w];
            else if (a)      m_cnt[w] = m_cnt[w] + 1;
            else if (c) begin
                if (m_cnt[w] == 0) m_err = 1;
                else               m_cnt[w] = m_cnt[w] - 1;
            end
            if (c) begin
                m_vl[w] = commit_vtype[7] ? 8'h00 : commit_vl;
                m_vt[w] = commit_vtype[7] ? 8'h80 : commit_vtype;
            end
        end
        e_rv = rd_valid;
        if (rd_valid) begin
            e_vl   = m_vl[rd_wid];
            e_vt   = m_vt[rd_wid];
            e_busy = (m_cnt[rd_wid] != 0);
        end
        #1;
        check("rd_rsp_valid", rd_rsp_valid, e_rv);
        check("rd_vl",        rd_vl,        e_vl);
        check("rd_vtype",     rd_vtype,     e_vt);
        check("rd_busy",      rd_busy,      e_busy);
        check("err",          err,          m_err);
    endtask

    task automatic drive(input bit av, input int aw, input bit cv, input int cw,
                         input int cvl, input int cvt, input bit fv, input int fw,
                         input bit rv, input int rw);
        alloc_valid  = av;
        alloc_wid    = 2'(aw);
        commit_valid = cv;
        commit_wid   = 2'(cw);
        commit_vl    = 8'(cvl);
        commit_vtype = 8'(cvt);
        flush_valid  = fv;
        flush_wid    = 2'(fw);
        rd_valid     = rv;
        rd_wid       = 2'(rw);
        cycle();
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic alloc(input int w);
        drive(1, w, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        reset_n = 1'b0;
        alloc_valid = 0; alloc_wid = 0; commit_valid = 0; commit_wid = 0;
        commit_vl = 0; commit_vtype = 0; flush_valid = 0; flush_wid = 0;
        rd_valid = 0; rd_wid = 0;
        model_reset();
        #12;
        check("reset_rsp_valid", rd_rsp_valid, 1'b0);
        check("reset_vtype",     rd_vtype,     8'h80);
        check("reset_err",       err,          1'b0);
        reset_n = 1'b1;

        // Query after reset returns the vill configuration.
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 2);
        check("t1_valid", rd_rsp_valid, 1'b1);
        check("t1_vl",    rd_vl,        8'h00);
        check("t1_vtype", rd_vtype,     8'h80);
        check("t1_busy",  rd_busy,      1'b0);

        // Fill warp 1, then retire one with a new config.
        alloc(1); alloc(1); alloc(1);
        alloc_valid = 0; alloc_wid = 2'd1;
        #1 check("t2_w1_full", alloc_ready, 1'b0);
        alloc_wid = 2'd0;
        #1 check("t2_w0_ready", alloc_ready, 1'b1);
        drive(0, 0, 1, 1, 16, 8'h0B, 0, 0, 1, 1);
        check("t2_vl",    rd_vl,    8'd16);
        check("t2_vtype", rd_vtype, 8'h0B);
        check("t2_busy",  rd_busy,  1'b1);
        alloc_wid = 2'd1;
        #1 check("t2_w1_ready", alloc_ready, 1'b1);

        // Same-cycle alloc+commit leaves the count alone; queries are write-first.
        alloc(0);
        drive(1, 0, 1, 0, 4, 8'h01, 0, 0, 1, 0);
        check("t3_busy_kept", rd_busy, 1'b1);
        drive(0, 0, 1, 0, 4, 8'h01, 0, 0, 1, 0);
        check("t3_drained", rd_busy, 1'b0);
        alloc(3);
        drive(0, 0, 1, 3, 8'h22, 8'h12, 0, 0, 1, 3);
        check("t3_wf_vl",    rd_vl,    8'h22);
        check("t3_wf_vtype", rd_vtype, 8'h12);

        // vill commit clears vl; a commit with nothing pending sets the sticky error.
        alloc(2);
        drive(0, 0, 1, 2, 9, 8'h85, 0, 0, 1, 2);
        check("t4_vill_vl",    rd_vl,    8'h00);
        check("t4_vill_vtype", rd_vtype, 8'h80);
        check("t4_no_err",     err,      1'b0);
        drive(0, 0, 1, 2, 5, 8'h03, 0, 0, 0, 0);
        check("t4_err_set", err, 1'b1);
        idle(); idle(); idle();
        check("t4_err_sticky", err, 1'b1);

        // Flush with a same-cycle alloc leaves exactly one pending, table untouched.
        drive(0, 0, 1, 1, 8'h30, 8'h0A, 0, 0, 0, 0);
        drive(0, 0, 1, 1, 8'h30, 8'h0A, 0, 0, 0, 0);
        alloc(1); alloc(1);
        drive(1, 1, 0, 0, 0, 0, 1, 1, 1, 1);
        check("t5_busy",  rd_busy,  1'b1);
        check("t5_vl",    rd_vl,    8'h30);
        check("t5_vtype", rd_vtype, 8'h0A);
        drive(0, 0, 1, 1, 8'h31, 8'h0A, 0, 0, 1, 1);
        check("t5_one_left", rd_busy, 1'b0);

        // Asynchronous reset in the middle of a cycle.
        alloc(0); alloc(0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        reset_n = 1'b0;
        #1;
        check("t6_rsp_valid", rd_rsp_valid, 1'b0);
        check("t6_vl",        rd_vl,        8'h00);
        check("t6_vtype",     rd_vtype,     8'h80);
        check("t6_busy",      rd_busy,      1'b0);
        check("t6_err",       err,          1'b0);
        alloc_valid = 0; commit_valid = 0; flush_valid = 0; rd_valid = 0;
        model_reset();
        #2 reset_n = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        check("t6_w0_idle", rd_busy, 1'b0);

        // Random traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            int vt;
            vt = int'($urandom_range(0, 255));
            if ($urandom_range(0, 3) != 0) vt = vt & 8'h7F;
            drive(bit'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                  bit'($urandom_range(0, 2) == 0), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 255)), vt,
                  bit'($urandom_range(0, 9) == 0), int'($urandom_range(0, 3)),
                  bit'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
